spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
//  SPI responder (target) for the far end of the system SPI master bus (spi_clk/spi_mosi/spi_miso/spi_cs_n).
//  Oversamples the SPI pins in the local clk domain; full-duplex byte exchange with valid/ready side buses.
//  Used as an on-FPGA loopback/peripheral target when bringing up and testing the SPI master.
// PARAMETERS
//  SYNC_STAGES  2      synchroniser flops on spi_clk/spi_mosi/spi_cs_n (legal: 2..3)
//  IDLE_BYTE    8'hFF  byte shifted out when no tx byte is pending at a byte boundary
// PORTS
//  clk          in   1  system clock; must be >= 4x spi_clk frequency
//  reset_n      in   1  asynchronous, active-low reset
//  spi_clk      in   1  SPI clock from master (async to clk)
//  spi_mosi     in   1  serial data from master
//  spi_cs_n     in   1  target select, active low
//  spi_miso     out  1  serial data to master
//  spi_miso_oe  out  1  MISO output enable (top-level tristate driver)
//  tx_data      in   8  next byte to send
//  tx_valid     in   1  tx_data valid
//  tx_ready     out  1  tx holding register empty
//  rx_data      out  8  last received byte
//  rx_valid     out  1  rx_data valid; held until rx_ready
//  rx_ready     in   1  consumer accepts rx_data
//  busy         out  1  selected (synchronised cs_n low)
//  overrun      out  1  sticky: byte completed while rx_valid still high
//  underrun     out  1  sticky: IDLE_BYTE sent because tx holding register empty
//  status_clr   in   1  clears overrun/underrun (single-cycle)
// BEHAVIOUR
//  Reset: spi_miso=1, spi_miso_oe=0, tx_ready=1, rx_data=0, rx_valid=0, busy=0, overrun=0, underrun=0; state IDLE.
//  Sync: all three pins pass SYNC_STAGES flops, then one edge-detect flop; edges seen SYNC_STAGES+1 clk after pin.
//  Mode 0 (default): sample MOSI on rising spi_clk, update MISO on falling spi_clk, MSB first.
//  TX handshake: tx_valid&tx_ready loads holding reg, tx_ready drops next cycle; reg freed when moved to shifter.
//  FSM IDLE: spi_miso_oe=0; on cs_n fall -> LOAD. LOAD (1 clk): shifter <= holding reg (or IDLE_BYTE + set underrun),
//   spi_miso <= shifter MSB, spi_miso_oe=1, bit_cnt=0 -> SHIFT.
//  SHIFT: rising edge -> rx_shift <= {rx_shift[6:0],mosi}, bit_cnt++; falling edge with bit_cnt!=0 -> MISO next bit.
//   bit_cnt==8 after rising edge: byte complete; if !rx_valid: rx_data<=byte, rx_valid=1 next clk; else drop, overrun=1.
//   falling edge after byte complete: reload shifter as in LOAD, bit_cnt=0 (back-to-back bytes, no gap needed).
//  rx_valid: cleared on rx_valid&rx_ready; simultaneous completion+accept -> new byte stored, no overrun.
//  rx_valid latency: exactly SYNC_STAGES+2 clk rising edges after the 8th spi_clk rising edge at the pin.
//  cs_n rise in any state -> IDLE next clk: partial byte discarded (no rx_valid), bit_cnt=0, oe=0, holding reg kept.
//  status_clr same cycle as a new overrun/underrun event: event wins (flag stays 1).
//  spi_clk edges while cs_n high are ignored. bit_cnt wraps 8->0 only via reload.
// CONFIGURATION
//  SPI_TARGET_MODE3_EN defined: CPOL=1/CPHA=1 -- idle spi_clk high, MISO updated on falling, MOSI sampled on rising,
//   first MISO bit driven on first falling edge (not at cs_n fall); LOAD leaves spi_miso=1 until that edge.
//  Undefined: mode 0 only, as described above. No runtime mode select in either build.
// TESTING
//  1 Reset: hold reset_n=0 mid-transfer -> all outputs at reset values immediately; no rx_valid after release.
//  2 tx=8'hA5 preloaded, master sends 8'h3C -> master reads 8'hA5; rx_data=8'h3C, rx_valid after SYNC_STAGES+2 clk.
//  3 Burst 3 bytes 8'h01,8'h02,8'h03, rx_ready held 1, tx fed 8'h10,8'h20,8'h30 -> 3 rx_valid, MISO 10/20/30.
//  4 No tx byte loaded -> master reads 8'hFF, underrun=1; status_clr pulse -> underrun=0.
//  5 rx_ready=0 across two bytes 8'h55,8'hAA -> rx_data stays 8'h55, overrun=1.
//  6 cs_n rises after 5 bits -> no rx_valid, spi_miso_oe=0; next full byte 8'hC3 received correctly.

Source files
------------

// File: rtl/spi_target.sv
// spi_target: SPI responder oversampled in the clk domain, full-duplex byte exchange
//   with valid/ready side buses. Default build is mode 0 (CPOL=0/CPHA=0).
//   Define SPI_TARGET_MODE3_EN for mode 3 (CPOL=1/CPHA=1).
// Ports:
//   clk, reset_n                    system clock (>= 4x spi_clk), async active-low reset
//   spi_clk, spi_mosi, spi_cs_n     SPI pins from the master (async to clk)
//   spi_miso, spi_miso_oe           serial data to master and its tristate enable
//   tx_data, tx_valid, tx_ready     next byte to send, one-entry holding register
//   rx_data, rx_valid, rx_ready     last received byte, held until accepted
//   busy                            synchronised chip select is active
//   overrun, underrun, status_clr   sticky error flags and their clear strobe
module spi_target #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       overrun,
  output logic       underrun,
  input  logic       status_clr
);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sclk_s, r_mosi_s, r_cs_s;
  logic r_sclk_d, r_cs_d;
  logic [7:0] r_hold, r_tx_shift, r_rx_shift, r_rx_data;
  logic r_hold_full, r_miso, r_rx_valid, r_done, r_overrun, r_underrun;
  logic [3:0] r_bit_cnt;
  logic w_sclk, w_mosi, w_cs, w_rise, w_fall, w_cs_fall;
  logic w_active, w_reload, w_load, w_drive, w_shift_out, w_rx_bit, w_ovr_evt, w_oe;
  logic [7:0] w_byte;

  assign w_sclk    = r_sclk_s[SYNC_STAGES-1];
  assign w_mosi    = r_mosi_s[SYNC_STAGES-1];
  assign w_cs      = r_cs_s[SYNC_STAGES-1];
  assign w_rise    = w_sclk & ~r_sclk_d;
  assign w_fall    = ~w_sclk & r_sclk_d;
  assign w_cs_fall = ~w_cs & r_cs_d;
  assign w_active  = (r_state == SHIFT) & ~w_cs;
  // Falling edge after a completed byte starts the next one without a gap.
  assign w_reload  = w_active & w_fall & (r_bit_cnt == 4'd8);
  assign w_load    = ((r_state == LOAD) & ~w_cs) | w_reload;
  assign w_byte    = r_hold_full ? r_hold : IDLE_BYTE;
  assign w_rx_bit  = w_active & w_rise & (r_bit_cnt != 4'd8);
  assign w_ovr_evt = r_done & r_rx_valid & ~rx_ready;

`ifdef SPI_TARGET_MODE3_EN
  // Mode 3: MSB goes out on the first falling edge, so LOAD only fills the shifter.
  assign w_drive     = w_reload;
  assign w_shift_out = w_active & w_fall & (r_bit_cnt != 4'd8);
`else
  // Mode 0: MSB is presented at LOAD; the falling edge before the first rise is not a shift.
  assign w_drive     = w_load;
  assign w_shift_out = w_active & w_fall & (r_bit_cnt != 4'd0) & (r_bit_cnt != 4'd8);
`endif

  always_comb begin
    w_next = w_cs ? IDLE : (r_state == IDLE) ? (w_cs_fall ? LOAD : IDLE) : (r_state == LOAD) ? SHIFT : r_state;
    w_oe   = r_state != IDLE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_sclk_s <= '0;
      r_mosi_s <= '0;
      r_cs_s   <= '1;
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_sclk_s <= {r_sclk_s[SYNC_STAGES-2:0], spi_clk};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], spi_cs_n};
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      if (w_load) r_hold_full <= 1'b0;
      if (tx_valid && !r_hold_full) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_bit_cnt  <= '0;
      r_miso     <= 1'b1;
      r_tx_shift <= '1;
      r_rx_shift <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_rx_bit & (r_bit_cnt == 4'd7);
      if (w_cs) begin
        r_bit_cnt <= '0;
        r_miso    <= 1'b1;
      end else begin
        if (w_load) begin
          r_bit_cnt  <= '0;
          r_tx_shift <= w_drive ? {w_byte[6:0], 1'b1} : w_byte;
          if (w_drive) r_miso <= w_byte[7];
        end else if (w_shift_out) begin
          r_miso     <= r_tx_shift[7];
          r_tx_shift <= {r_tx_shift[6:0], 1'b1};
        end
        if (w_rx_bit) begin
          r_rx_shift <= {r_rx_shift[6:0], w_mosi};
          r_bit_cnt  <= r_bit_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      // A byte completing in the same cycle the consumer accepts replaces the old one.
      if (r_done && !(r_rx_valid && !rx_ready)) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      r_overrun  <= w_ovr_evt | (r_overrun & ~status_clr);
      r_underrun <= (w_load & ~r_hold_full) | (r_underrun & ~status_clr);
    end
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = w_oe;
  assign tx_ready    = ~r_hold_full;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign busy        = ~w_cs;
  assign overrun     = r_overrun;
  assign underrun    = r_underrun;
endmodule

// File: tb/tb_spi_target.sv
// tb_spi_target: mode-0 master model driving spi_target with a received-byte scoreboard.
module tb_spi_target;
  localparam int SS = 2;
  localparam int H  = 8;
  logic clk = 1'b0, reset_n = 1'b0;
  logic spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs_n = 1'b1;
  logic spi_miso, spi_miso_oe, tx_ready, rx_valid, busy, overrun, underrun;
  logic [7:0] tx_data = '0, rx_data;
  logic tx_valid = 1'b0, rx_ready = 1'b1, status_clr = 1'b0;
  int n_vec = 0, n_err = 0, cyc = 0, r8_cyc = 0;
  logic lat_en = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] m, m1, m2, m3;

  spi_target #(.SYNC_STAGES(SS), .IDLE_BYTE(8'hFF)) dut (
    .clk(clk), .reset_n(reset_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi), .spi_cs_n(spi_cs_n),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .busy(busy), .overrun(overrun), .underrun(underrun), .status_clr(status_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk)
    if (reset_n && rx_valid && rx_ready) begin
      if (rxq.size() == 0) check("rx_unexpected", rxq.size(), 1);
      else begin
        check("rx_data", rx_data, rxq.pop_front());
        if (lat_en) check("rx_latency", cyc - r8_cyc, SS + 2);
      end
    end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bits(input logic [7:0] b, input int n, output logic [7:0] r);
    r = '0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      wait_clk(H);
      r[i] = spi_miso;
      spi_clk = 1'b1;
      if (i == 0) r8_cyc = cyc;
      wait_clk(H);
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(H);
  endtask

  task automatic cs_high();
    wait_clk(H);
    spi_cs_n = 1'b1;
    wait_clk(2 * H);
  endtask

  task automatic feed(input logic [7:0] d);
    int k = 0;
    while (!tx_ready && k < 400) begin
      wait_clk(1);
      k++;
    end
    if (!tx_ready) check("tx_ready_timeout", tx_ready, 1);
    tx_data = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic clear_status();
    status_clr = 1'b1;
    wait_clk(1);
    status_clr = 1'b0;
    wait_clk(1);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && rxq.size() != 0; k++) wait_clk(1);
    check("rx_drain", rxq.size(), 0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: time limit reached, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    wait_clk(3);
    check("rst_miso", spi_miso, 1);
    check("rst_oe", spi_miso_oe, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx", {rx_valid, rx_data}, 0);
    check("rst_flags", {busy, overrun, underrun}, 0);
    reset_n = 1'b1;
    wait_clk(4);

    // preloaded A5 goes out while 3C comes in
    feed(8'hA5);
    check("t2_tx_ready", tx_ready, 0);
    cs_low();
    check("t2_busy_oe", {busy, spi_miso_oe}, 2'b11);
    lat_en = 1'b1;
    rxq.push_back(8'h3C);
    bits(8'h3C, 8, m);
    cs_high();
    lat_en = 1'b0;
    check("t2_miso", m, 8'hA5);
    drain();
    check("t2_rx_data", rx_data, 8'h3C);

    // reset asserted in the middle of a transfer
    feed(8'h77);
    cs_low();
    feed(8'h66);
    bits(8'hF0, 4, m);
    #3 reset_n = 1'b0;
    #1;
    check("t1_miso", spi_miso, 1);
    check("t1_oe", spi_miso_oe, 0);
    check("t1_tx_ready", tx_ready, 1);
    check("t1_rx", {rx_valid, rx_data}, 0);
    check("t1_flags", {busy, overrun, underrun}, 0);
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(H);
    bits(8'h0F, 4, m);
    cs_high();
    wait_clk(10);
    check("t1_no_rx", rx_valid, 0);

    // back-to-back burst with holding register refilled mid-transfer
    clear_status();
    feed(8'h10);
    cs_low();
    rxq.push_back(8'h01);
    rxq.push_back(8'h02);
    rxq.push_back(8'h03);
    fork
      begin
        bits(8'h01, 8, m1);
        bits(8'h02, 8, m2);
        bits(8'h03, 8, m3);
      end
      begin
        feed(8'h20);
        feed(8'h30);
      end
    join
    cs_high();
    check("t3_miso0", m1, 8'h10);
    check("t3_miso1", m2, 8'h20);
    check("t3_miso2", m3, 8'h30);
    drain();

    // nothing to send: idle byte plus underrun
    clear_status();
    check("t4_underrun_clr0", underrun, 0);
    cs_low();
    rxq.push_back(8'h5A);
    bits(8'h5A, 8, m);
    cs_high();
    check("t4_miso_idle", m, 8'hFF);
    check("t4_underrun", underrun, 1);
    drain();
    clear_status();
    check("t4_underrun_clr", underrun, 0);

    // consumer stalled across two bytes
    rx_ready = 1'b0;
    cs_low();
    bits(8'h55, 8, m);
    bits(8'hAA, 8, m);
    cs_high();
    check("t5_rx_data", rx_data, 8'h55);
    check("t5_rx_valid", rx_valid, 1);
    check("t5_overrun", overrun, 1);
    rxq.push_back(8'h55);
    rx_ready = 1'b1;
    drain();
    check("t5_overrun_held", overrun, 1);
    clear_status();
    check("t5_overrun_clr", overrun, 0);

    // aborted partial byte, then a clean one
    cs_low();
    bits(8'hFF, 5, m);
    cs_high();
    check("t6_oe", spi_miso_oe, 0);
    check("t6_busy", busy, 0);
    check("t6_no_rx", rx_valid, 0);
    cs_low();
    rxq.push_back(8'hC3);
    bits(8'hC3, 8, m);
    cs_high();
    drain();
    check("t6_rx_data", rx_data, 8'hC3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
